// File: rtl/frontend_hazard_ctrl_if.sv
// Handshake bundle between the front-end pipeline/ROB side and the hazard controller.
// master: pipeline/ROB side that drives hazard sources; slave: the controller.
interface frontend_hazard_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  logic                  imem_miss;
  logic                  can_dispatch;
  logic                  flush_valid;
  logic [1:0]            rob_state;
  logic [31:0]           pc_is_read;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  halted;
  logic                  miss_timeout;
  logic [31:0]           stall_cnt;
  logic [15:0]           flush_cnt;

  modport master (
    output imem_miss, can_dispatch, flush_valid, rob_state, pc_is_read,
    input  stall, flush, halted, miss_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  imem_miss, can_dispatch, flush_valid, rob_state, pc_is_read,
    output stall, flush, halted, miss_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/frontend_hazard_ctrl.sv
// Stall/flush controller for the in-order front end (PC..ID): per-stage hold and
// bubble vectors, recovery FSM with multi-cycle flush hold, miss watchdog and counters.
module frontend_hazard_ctrl #(
  parameter int NUM_STAGES   = 4,
  parameter int IMEM_ADDR_W  = 10,
  parameter int FETCH_BYTES  = 8,
  parameter int FLUSH_HOLD   = 1,
  parameter int MISS_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  frontend_hazard_ctrl_if.slave bus
);

  localparam int FETCH_LSB = $clog2(FETCH_BYTES);
  localparam int HOLD_W    = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam int MISS_W    = $clog2(MISS_TIMEOUT + 1);

  localparam logic [1:0] ROB_IDLE = 2'b00;

  // Fetch-group index bits of the PC; run_out when all of them are ones.
  localparam logic [63:0] ADDR_MASK  = (64'd1 << IMEM_ADDR_W) - 64'd1;
  localparam logic [63:0] LSB_MASK   = (64'd1 << FETCH_LSB) - 64'd1;
  localparam logic [31:0] GROUP_MASK = 32'(ADDR_MASK & ~LSB_MASK);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_RECOVER,
    ST_HALT
  } state_t;

  state_t                state_reg, state_next;
  logic [HOLD_W-1:0]     hold_reg, hold_next;
  logic [MISS_W-1:0]     miss_run_reg, miss_run_next;
  logic                  miss_timeout_reg, miss_timeout_next;
  logic [31:0]           stall_cnt_reg, stall_cnt_next;
  logic [15:0]           flush_cnt_reg, flush_cnt_next;

  logic                  bp;
  logic                  rob_busy;
  logic                  run_out;
  logic                  halted_c;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_raw;
  logic [NUM_STAGES-1:0] stall_res;

  assign rob_busy = (bus.rob_state != ROB_IDLE);
  assign bp       = ~bus.can_dispatch | rob_busy;
  assign run_out  = &(bus.pc_is_read | ~GROUP_MASK);

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    stall_raw  = '0;
    flush_raw  = '0;
    halted_c   = 1'b0;

    case (state_reg)
      ST_RUN: begin
        stall_raw    = {NUM_STAGES{bp}};
        stall_raw[0] = bus.imem_miss | bp | run_out;
        flush_raw[1] = bus.imem_miss & ~bp;
        if (run_out) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        // PC parked; IF gets bubbles while older groups drain under bp.
        halted_c     = 1'b1;
        stall_raw    = {NUM_STAGES{bp}};
        stall_raw[0] = 1'b1;
        flush_raw[1] = ~bp;
      end
      ST_FLUSH: begin
        flush_raw    = '1;
        flush_raw[0] = 1'b0;
        stall_raw[0] = 1'b1;
        hold_next    = hold_reg - HOLD_W'(1);
        if (hold_reg <= HOLD_W'(1)) begin
          state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        stall_raw = '1;
        if (!rob_busy) begin
          state_next = run_out ? ST_HALT : ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    // A redirect overrides every state; the PC takes the new target this cycle.
    if (bus.flush_valid) begin
      flush_raw    = '1;
      flush_raw[0] = 1'b0;
      stall_raw[0] = 1'b0;
      hold_next    = HOLD_W'(FLUSH_HOLD - 1);
      state_next   = (FLUSH_HOLD == 1) ? ST_RECOVER : ST_FLUSH;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign stall_res[gi] = stall_raw[gi] & ~flush_raw[gi];
    end
  endgenerate

  always_comb begin
    miss_run_next = '0;
    if (bus.imem_miss) begin
      miss_run_next = (miss_run_reg == MISS_W'(MISS_TIMEOUT)) ? miss_run_reg
                                                               : miss_run_reg + MISS_W'(1);
    end
    miss_timeout_next = miss_timeout_reg | (miss_run_next == MISS_W'(MISS_TIMEOUT));
    stall_cnt_next    = stall_cnt_reg;
    if (stall_res[0] && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
    flush_cnt_next = flush_cnt_reg + {15'd0, bus.flush_valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_RUN;
      hold_reg         <= '0;
      miss_run_reg     <= '0;
      miss_timeout_reg <= 1'b0;
      stall_cnt_reg    <= '0;
      flush_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      hold_reg         <= hold_next;
      miss_run_reg     <= miss_run_next;
      miss_timeout_reg <= miss_timeout_next;
      stall_cnt_reg    <= stall_cnt_next;
      flush_cnt_reg    <= flush_cnt_next;
    end
  end

  // While reset is held the whole front end freezes regardless of inputs.
  assign bus.stall        = reset_n ? stall_res : '1;
  assign bus.flush        = reset_n ? flush_raw : '0;
  assign bus.halted       = reset_n & halted_c;
  assign bus.miss_timeout = miss_timeout_reg;
  assign bus.stall_cnt    = stall_cnt_reg;
  assign bus.flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_frontend_hazard_ctrl.sv
// Directed bench for frontend_hazard_ctrl (NUM_STAGES=4, FLUSH_HOLD=3, MISS_TIMEOUT=4).
module tb_frontend_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_scnt = '0;
  logic [15:0] exp_fcnt = '0;
  logic        exp_mto = 1'b0;

  frontend_hazard_ctrl_if #(.NUM_STAGES(4)) bus ();

  frontend_hazard_ctrl #(
    .NUM_STAGES  (4),
    .IMEM_ADDR_W (10),
    .FETCH_BYTES (8),
    .FLUSH_HOLD  (3),
    .MISS_TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic cd, input logic fv,
                       input logic [1:0] rob, input logic [31:0] pc);
    bus.imem_miss    = m;
    bus.can_dispatch = cd;
    bus.flush_valid  = fv;
    bus.rob_state    = rob;
    bus.pc_is_read   = pc;
  endtask

  // One cycle: apply inputs after the falling edge, check before the rising edge.
  task automatic step(input logic m, input logic cd, input logic fv,
                      input logic [1:0] rob, input logic [31:0] pc,
                      input logic [3:0] es, input logic [3:0] ef, input logic eh,
                      input string tag);
    @(negedge clk);
    drive(m, cd, fv, rob, pc);
    #1;
    chk({tag, "_stall"}, {28'd0, bus.stall}, {28'd0, es});
    chk({tag, "_flush"}, {28'd0, bus.flush}, {28'd0, ef});
    chk({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, eh});
    chk({tag, "_mto"}, {31'd0, bus.miss_timeout}, {31'd0, exp_mto});
    chk({tag, "_scnt"}, bus.stall_cnt, exp_scnt);
    chk({tag, "_fcnt"}, {16'd0, bus.flush_cnt}, {16'd0, exp_fcnt});
    $display("step %s stall=%b flush=%b halted=%b scnt=%0h fcnt=%0d",
             tag, bus.stall, bus.flush, bus.halted, bus.stall_cnt, bus.flush_cnt);
    if (es[0] && (exp_scnt != 32'hFFFF_FFFF)) exp_scnt++;
    if (fv) exp_fcnt++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"}, {28'd0, bus.stall}, 32'hF);
    chk({tag, "_flush"}, {28'd0, bus.flush}, 32'h0);
    chk({tag, "_halted"}, {31'd0, bus.halted}, 32'h0);
    chk({tag, "_mto"}, {31'd0, bus.miss_timeout}, 32'h0);
    chk({tag, "_scnt"}, bus.stall_cnt, 32'h0);
    chk({tag, "_fcnt"}, {16'd0, bus.flush_cnt}, 32'h0);
  endtask

  initial begin
    // Reset with busy inputs
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'h3F8);
    #2;
    chk_reset_state("rst0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_state("rst1");
    #1;
    drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    reset_n = 1'b1;
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "release");

    // Miss without and with backpressure
    repeat (3) step(1, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b0010, 0, "miss_nobp");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "idle_a");
    repeat (3) step(1, 0, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "miss_bp");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "idle_b");
    step(0, 1, 0, 2'd2, 32'h0, 4'b1111, 4'b0000, 0, "rob_walk");
    step(0, 1, 0, 2'd3, 32'h0, 4'b1111, 4'b0000, 0, "rob_3");

    // Flush with 3-cycle hold, then ROB recovery
    step(0, 1, 1, 2'd0, 32'h0, 4'b0000, 4'b1110, 0, "fv");
    repeat (2) step(0, 1, 0, 2'd1, 32'h0, 4'b0001, 4'b1110, 0, "fl_hold");
    repeat (2) step(0, 1, 0, 2'd2, 32'h0, 4'b1111, 4'b0000, 0, "rec_walk");
    step(0, 1, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "rec_idle");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "run_again");

    // Redirect during FLUSH restarts the hold
    step(0, 1, 1, 2'd0, 32'h0, 4'b0000, 4'b1110, 0, "fv_a");
    step(0, 1, 1, 2'd0, 32'h0, 4'b0000, 4'b1110, 0, "fv_b");
    repeat (2) step(0, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b1110, 0, "rs_hold");
    step(0, 1, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "rs_rec");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "rs_run");

    // End of program memory
    step(0, 1, 0, 2'd0, 32'h3F0, 4'b0000, 4'b0000, 0, "not_eop");
    step(0, 1, 0, 2'd0, 32'h3F8, 4'b0001, 4'b0000, 0, "eop_run");
    step(0, 1, 0, 2'd0, 32'h3F8, 4'b0001, 4'b0010, 1, "halt");
    step(0, 0, 0, 2'd0, 32'h3F8, 4'b1111, 4'b0000, 1, "halt_bp");
    step(0, 1, 1, 2'd0, 32'h3F8, 4'b0000, 4'b1110, 1, "halt_fv");
    repeat (2) step(0, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b1110, 0, "halt_fl");
    step(0, 1, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "halt_rec");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "halt_run");

    // Watchdog: 3 misses, gap, 4 misses
    repeat (3) step(1, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b0010, 0, "wd_a");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "wd_gap");
    repeat (4) step(1, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b0010, 0, "wd_b");
    exp_mto = 1'b1;
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "wd_set");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "wd_sticky");

    // Stall counter saturation
    #1;
    force dut.stall_cnt_reg = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_reg;
    exp_scnt = 32'hFFFF_FFFD;
    repeat (4) step(0, 0, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "scnt_sat");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "scnt_hold");

    // Reset in the middle of a flush: back to RUN, nothing replayed
    step(0, 1, 1, 2'd0, 32'h0, 4'b0000, 4'b1110, 0, "pre_rst_fv");
    @(negedge clk);
    drive(0, 1, 0, 2'd0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    #1;
    reset_n  = 1'b1;
    exp_scnt = '0;
    exp_fcnt = '0;
    exp_mto  = 1'b0;
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "post_rst");

    // 65537 redirects wrap the 16-bit flush counter to 1
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 2'd0, 32'h0);
      exp_fcnt++;
    end
    repeat (2) step(0, 1, 0, 2'd0, 32'h0, 4'b0001, 4'b1110, 0, "wrap_hold");
    step(0, 1, 0, 2'd0, 32'h0, 4'b1111, 4'b0000, 0, "wrap_rec");
    step(0, 1, 0, 2'd0, 32'h0, 4'b0000, 4'b0000, 0, "wrap_run");
    chk("fcnt_wrap_abs", {16'd0, bus.flush_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
